// File: rtl/vlc_bit_packer.sv
// Packs variable-length codes MSB-first into OUT_W-bit words, with optional JPEG
// 0xFF/0x00 byte stuffing and a flush that pads to a byte and emits the tail word.
module vlc_bit_packer #(
  parameter int LANES  = 8,
  parameter int CODE_W = 32,
  parameter int LEN_W  = 5,
  parameter int OUT_W  = 32,
  parameter int ACC_W  = 2 * CODE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*CODE_W-1:0]  in_code,
  input  logic [LANES*LEN_W-1:0]   in_len,
  input  logic                     stuff_en,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(OUT_W/8):0] out_nbytes,
  output logic                     out_last,
  output logic [31:0]              byte_cnt
);

  // valid/ready: a transfer happens on a rising edge where both are high; the
  // sender holds its payload unchanged while valid && !ready.
  localparam int NB     = OUT_W / 8;
  localparam int NB_W   = $clog2(NB) + 1;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int SH_W   = FILL_W + 1;
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {IDLE, LANE, FLUSH_PAD, FLUSH_DRAIN, FLUSH_OUT} state_t;

  state_t                  state, state_nx;
  logic [LANES*CODE_W-1:0] code_r;
  logic [LANES*LEN_W-1:0]  len_r;
  logic [IDX_W-1:0]        idx;
  logic [ACC_W-1:0]        acc, acc_nx, app_bits;
  logic [FILL_W-1:0]       fill, fill_p, fill_nx, app_len;
  logic [SH_W-1:0]         app_sh;
  logic [CODE_W-1:0]       app_code;
  logic [OUT_W-1:0]        asm_data;
  logic [NB_W-1:0]         asm_cnt;
  logic                    stuff_pend, flush_pending;
  logic                    pop_data, pop_stuff;
  logic [7:0]              pop_byte;
  logic                    fits, do_app;
  logic                    accept, out_free, move_full, load_last, last_hs;

  function automatic logic [FILL_W-1:0] sat_len(input logic [LEN_W-1:0] l);
    int v;
    v = int'(l);
    if (v > CODE_W) v = CODE_W;
    return FILL_W'(v);
  endfunction

  assign in_ready  = (state == IDLE) && !flush_pending;
  assign accept    = in_valid && in_ready;
  assign out_free  = !out_valid || out_ready;
  assign move_full = (asm_cnt == NB_W'(NB)) && out_free;
  assign load_last = (state == FLUSH_OUT) && out_free && !(out_valid && out_last);
  assign last_hs   = (state == FLUSH_OUT) && out_valid && out_ready && out_last;

  // Byte stage: a pending stuff byte always wins over fresh accumulator data.
  always_comb begin
    pop_data  = 1'b0;
    pop_stuff = 1'b0;
    pop_byte  = 8'h00;
    if (asm_cnt < NB_W'(NB)) begin
      if (stuff_pend) begin
        pop_stuff = 1'b1;
      end else if (fill >= FILL_W'(8)) begin
        pop_data = 1'b1;
        pop_byte = acc[ACC_W-1 -: 8];
      end
    end
  end

  // The accumulator is MSB-aligned: the next stream bit is acc[ACC_W-1].
  always_comb begin
    app_len  = '0;
    app_code = '0;
    case (state)
      LANE: begin
        app_len  = sat_len(len_r[int'(idx)*LEN_W +: LEN_W]);
        app_code = code_r[int'(idx)*CODE_W +: CODE_W];
      end
      FLUSH_PAD: begin
        if (fill[2:0] != 3'd0) app_len = FILL_W'(4'd8 - {1'b0, fill[2:0]});
        app_code = '1;
      end
      default: ;
    endcase
    fits     = ({1'b0, fill} + {1'b0, app_len}) <= SH_W'(ACC_W);
    do_app   = fits && ((state == LANE) || (state == FLUSH_PAD));
    fill_p   = pop_data ? (fill - FILL_W'(8)) : fill;
    app_sh   = SH_W'(ACC_W) - {1'b0, fill_p} - {1'b0, app_len};
    app_bits = ({{(ACC_W-CODE_W){1'b0}}, app_code} & ~({ACC_W{1'b1}} << app_len)) << app_sh;
    acc_nx   = pop_data ? {acc[ACC_W-9:0], 8'h00} : acc;
    fill_nx  = fill_p;
    if (do_app) begin
      acc_nx  = acc_nx | app_bits;
      fill_nx = fill_p + app_len;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept)     state_nx = LANE;
        else if (flush) state_nx = FLUSH_PAD;
      end
      LANE: begin
        if (fits && (idx == IDX_W'(LANES-1)))
          state_nx = (flush_pending || flush) ? FLUSH_PAD : IDLE;
      end
      FLUSH_PAD:   if (fits) state_nx = FLUSH_DRAIN;
      // A full assembler leaves as an ordinary word before the tail word is built.
      FLUSH_DRAIN: if ((fill == '0) && !stuff_pend && (asm_cnt < NB_W'(NB))) state_nx = FLUSH_OUT;
      FLUSH_OUT:   if (last_hs) state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_r        <= '0;
      len_r         <= '0;
      idx           <= '0;
      acc           <= '0;
      fill          <= '0;
      asm_data      <= '0;
      asm_cnt       <= '0;
      stuff_pend    <= 1'b0;
      flush_pending <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_nbytes    <= '0;
      out_last      <= 1'b0;
      byte_cnt      <= '0;
    end else begin
      if (accept) begin
        code_r <= in_code;
        len_r  <= in_len;
        idx    <= '0;
      end else if ((state == LANE) && fits) begin
        idx <= idx + 1'b1;
      end

      acc  <= acc_nx;
      fill <= fill_nx;

      if (pop_stuff)                                        stuff_pend <= 1'b0;
      else if (pop_data && (pop_byte == 8'hFF) && stuff_en) stuff_pend <= 1'b1;

      if (last_hs)    flush_pending <= 1'b0;
      else if (flush) flush_pending <= 1'b1;

      if (out_valid && out_ready) byte_cnt <= byte_cnt + 32'(out_nbytes);

      if (move_full) begin
        out_valid  <= 1'b1;
        out_data   <= asm_data;
        out_nbytes <= NB_W'(NB);
        out_last   <= 1'b0;
        asm_data   <= '0;
        asm_cnt    <= '0;
      end else if (load_last) begin
        out_valid  <= 1'b1;
        out_data   <= asm_data;
        out_nbytes <= asm_cnt;
        out_last   <= 1'b1;
        asm_data   <= '0;
        asm_cnt    <= '0;
      end else begin
        if (out_valid && out_ready) out_valid <= 1'b0;
        if (pop_data || pop_stuff) begin
          asm_data[(NB-1-int'(asm_cnt))*8 +: 8] <= pop_byte;
          asm_cnt <= asm_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vlc_bit_packer.sv
// Bench for vlc_bit_packer: a bit/byte queue model of the stream, a negedge
// monitor comparing every output handshake, directed cases and random images.
module tb_vlc_bit_packer;
  localparam int LANES  = 8;
  localparam int CODE_W = 32;
  localparam int LEN_W  = 5;
  localparam int OUT_W  = 32;
  localparam int NB_W   = 3;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [LANES*CODE_W-1:0] in_code = '0;
  logic [LANES*LEN_W-1:0]  in_len = '0;
  logic                    stuff_en = 1'b0;
  logic                    flush = 1'b0;
  logic                    out_valid;
  logic                    out_ready;
  logic [OUT_W-1:0]        out_data;
  logic [NB_W-1:0]         out_nbytes;
  logic                    out_last;
  logic [31:0]             byte_cnt;

  vlc_bit_packer #(.LANES(LANES), .CODE_W(CODE_W), .LEN_W(LEN_W), .OUT_W(OUT_W), .ACC_W(2*CODE_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .in_len(in_len), .stuff_en(stuff_en), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_nbytes(out_nbytes),
    .out_last(out_last), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          hs_bytes = 0;
  int          ready_mode = 2;  // 0 random, 1 held low, 2 held high
  logic [35:0] exp_q[$];        // {last, nbytes, data}
  logic [35:0] got_q[$];
  bit          bitq[$];
  logic [7:0]  byteq[$];
  logic        prev_stall = 1'b0;
  logic [35:0] prev_word;
  logic [35:0] mon_exp;
  logic [LANES*CODE_W-1:0] rc;
  logic [LANES*LEN_W-1:0]  rl;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [35:0] mk_word(input logic last, input logic [2:0] nb, input logic [31:0] d);
    return {last, nb, d};
  endfunction

  function automatic logic [35:0] got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 36'hF_FFFF_FFFF;
  endfunction

  // ---------------- stream model ----------------
  task automatic model_drain();
    logic [7:0]  b;
    logic [31:0] w;
    while (bitq.size() >= 8) begin
      b = 8'h00;
      for (int k = 0; k < 8; k++) b = {b[6:0], bitq.pop_front()};
      byteq.push_back(b);
      if (b == 8'hFF && stuff_en) byteq.push_back(8'h00);
    end
    while (byteq.size() >= 4) begin
      w = 32'h0;
      for (int k = 0; k < 4; k++) w = {w[23:0], byteq.pop_front()};
      exp_q.push_back(mk_word(1'b0, 3'd4, w));
    end
  endtask

  task automatic model_beat(input logic [LANES*CODE_W-1:0] codes, input logic [LANES*LEN_W-1:0] lens);
    int l;
    for (int i = 0; i < LANES; i++) begin
      l = int'(lens[i*LEN_W +: LEN_W]);
      if (l > CODE_W) l = CODE_W;
      for (int b = l - 1; b >= 0; b--) bitq.push_back(codes[i*CODE_W + b]);
    end
    model_drain();
  endtask

  task automatic model_flush();
    logic [31:0] w;
    int k;
    while (bitq.size() % 8 != 0) bitq.push_back(1'b1);
    model_drain();
    w = 32'h0;
    k = byteq.size();
    for (int j = 0; j < k; j++) w[31-8*j -: 8] = byteq.pop_front();
    exp_q.push_back(mk_word(1'b1, 3'(k), w));
  endtask

  // ---------------- consumer and monitor ----------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_word", 64'({out_last, out_nbytes, out_data}), 64'(prev_word));
      end
      if (out_valid && out_ready) begin
        check("byte_cnt", 64'(byte_cnt), 64'(32'(hs_bytes)));
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", {out_last, out_nbytes, out_data});
        end else begin
          mon_exp = exp_q.pop_front();
          check("word", 64'({out_last, out_nbytes, out_data}), 64'(mon_exp));
          hs_bytes += int'(mon_exp[34:32]);
        end
        got_q.push_back({out_last, out_nbytes, out_data});
      end
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_nbytes, out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_nbytes", 64'(out_nbytes), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_byte_cnt", 64'(byte_cnt), 64'd0);
    exp_q.delete();
    got_q.delete();
    bitq.delete();
    byteq.delete();
    hs_bytes = 0;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic send_beat(input logic [LANES*CODE_W-1:0] codes, input logic [LANES*LEN_W-1:0] lens, input logic fl);
    int t;
    t = 0;
    while (!in_ready && t < 3000) begin cycle(); t++; end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=in_ready_low required=in_ready_high");
    end else begin
      in_valid = 1'b1;
      in_code  = codes;
      in_len   = lens;
      flush    = fl;
      model_beat(codes, lens);
      if (fl) model_flush();
      cycle();
      in_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  task automatic send_flush();
    flush = 1'b1;
    model_flush();
    cycle();
    flush = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || !in_ready) && t < 5000) begin cycle(); t++; end
    check(name, 64'(t < 5000), 64'd1);
  endtask

  task automatic run_random();
    int nbeats, fm, r, len;
    for (int img = 0; img < 30; img++) begin
      stuff_en = 1'($urandom_range(0, 1));
      nbeats = $urandom_range(1, 3);
      fm = $urandom_range(0, 2);
      for (int n = 0; n < nbeats; n++) begin
        for (int i = 0; i < LANES; i++) begin
          r = $urandom_range(0, 9);
          if (r < 2)      len = 0;
          else if (r < 4) len = 31;
          else            len = $urandom_range(1, 31);
          rl[i*LEN_W +: LEN_W]   = LEN_W'(len);
          rc[i*CODE_W +: CODE_W] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
        end
        send_beat(rc, rl, (n == nbeats - 1) && (fm == 0));
      end
      if (fm == 1) send_flush();
      if (fm == 2) begin
        wait_done("rand_pre_flush");
        send_flush();
      end
      wait_done("rand_image");
    end
  endtask

  // ---------------- sequence ----------------
  logic [35:0] cap;
  int          t0;

  initial begin
    cycle();
    do_reset();

    // Eight 4-bit codes 1..8 then a flush while lanes are still in flight.
    ready_mode = 2;
    stuff_en = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      rc[i*CODE_W +: CODE_W] = 32'(i + 1);
      rl[i*LEN_W +: LEN_W]   = 5'd4;
    end
    send_beat(rc, rl, 1'b0);
    send_flush();
    wait_done("t1_done");
    check("t1_count", 64'(got_q.size()), 64'd2);
    check("t1_word0", 64'(got_at(0)), 64'(mk_word(1'b0, 3'd4, 32'h12345678)));
    check("t1_word1", 64'(got_at(1)), 64'(mk_word(1'b1, 3'd0, 32'h0)));
    check("t1_byte_cnt", 64'(byte_cnt), 64'd4);

    // 3-bit code followed by a flush from IDLE: padded with ones.
    got_q.delete();
    rc = '0;
    rl = '0;
    rc[2:0] = 3'b101;
    rl[4:0] = 5'd3;
    send_beat(rc, rl, 1'b0);
    wait_done("t2_beat");
    send_flush();
    wait_done("t2_done");
    check("t2_word", 64'(got_at(0)), 64'(mk_word(1'b1, 3'd1, 32'hBF000000)));

    // 0xFF with and without stuffing, flush in the accept cycle.
    got_q.delete();
    t0 = int'(byte_cnt);
    stuff_en = 1'b1;
    rc = '0;
    rl = '0;
    rc[7:0] = 8'hFF;
    rl[4:0] = 5'd8;
    send_beat(rc, rl, 1'b1);
    wait_done("t3_done");
    check("t3_stuffed", 64'(got_at(0)), 64'(mk_word(1'b1, 3'd2, 32'hFF000000)));
    check("t3_byte_delta", 64'(int'(byte_cnt) - t0), 64'd2);
    stuff_en = 1'b0;
    send_beat(rc, rl, 1'b1);
    wait_done("t3b_done");
    check("t3_unstuffed", 64'(got_at(1)), 64'(mk_word(1'b1, 3'd1, 32'hFF000000)));

    // Eight 31-bit all-ones codes with flush at accept: capacity stalls, 31 bytes out.
    got_q.delete();
    for (int i = 0; i < LANES; i++) begin
      rc[i*CODE_W +: CODE_W] = 32'hFFFF_FFFF;
      rl[i*LEN_W +: LEN_W]   = 5'd31;
    end
    send_beat(rc, rl, 1'b1);
    t0 = 0;
    while (!in_ready && t0 < 3000) begin cycle(); t0++; end
    check("t4_words_before_ready", 64'(got_q.size()), 64'd8);
    check("t4_first", 64'(got_at(0)), 64'(mk_word(1'b0, 3'd4, 32'hFFFFFFFF)));
    check("t4_last", 64'(got_at(7)), 64'(mk_word(1'b1, 3'd3, 32'hFFFFFF00)));

    // Backpressure: word held stable for 10 cycles, then released.
    got_q.delete();
    ready_mode = 1;
    for (int i = 0; i < LANES; i++) begin
      rc[i*CODE_W +: CODE_W] = 32'(15 - i);
      rl[i*LEN_W +: LEN_W]   = 5'd4;
    end
    send_beat(rc, rl, 1'b0);
    t0 = 0;
    while (!out_valid && t0 < 100) begin cycle(); t0++; end
    check("t5_valid_seen", 64'(out_valid), 64'd1);
    cap = {out_last, out_nbytes, out_data};
    for (int k = 0; k < 10; k++) begin
      cycle();
      check("t5_bp_valid", 64'(out_valid), 64'd1);
      check("t5_bp_word", 64'({out_last, out_nbytes, out_data}), 64'(cap));
    end
    ready_mode = 0;
    send_flush();
    wait_done("t5_done");
    check("t5_count", 64'(got_q.size()), 64'd2);
    check("t5_word0", 64'(got_at(0)), 64'(mk_word(1'b0, 3'd4, 32'hFEDCBA98)));

    // Reset while the lane walk is at idx 4; only the new beat must appear.
    ready_mode = 2;
    for (int i = 0; i < LANES; i++) begin
      rc[i*CODE_W +: CODE_W] = 32'h5;
      rl[i*LEN_W +: LEN_W]   = 5'd4;
    end
    send_beat(rc, rl, 1'b0);
    repeat (4) cycle();
    do_reset();
    rc = '0;
    rl = '0;
    rc[7:0]   = 8'hC3;
    rl[4:0]   = 5'd8;
    rc[39:32] = 8'h5A;
    rl[9:5]   = 5'd8;
    send_beat(rc, rl, 1'b1);
    wait_done("t6_done");
    check("t6_count", 64'(got_q.size()), 64'd1);
    check("t6_word", 64'(got_at(0)), 64'(mk_word(1'b1, 3'd2, 32'hC35A0000)));
    check("t6_byte_cnt", 64'(byte_cnt), 64'd2);

    ready_mode = 0;
    run_random();

    check("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
